// File: rtl/paddle_mover_pkg.sv
// rtl/paddle_mover_pkg.sv - shared VGA visible-area constants and paddle helpers
package paddle_mover_pkg;

  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;

  typedef enum logic [1:0] {
    MOVE_HOLD = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } move_t;

  // Saturate a signed candidate row into [0, hi]; hi always fits in 9 bits.
  function automatic logic [8:0] clamp_row(input logic signed [10:0] v,
                                           input logic signed [10:0] hi);
    logic [8:0] r;
    if (v < 11'sd0)
      r = 9'd0;
    else if (v > hi)
      r = hi[8:0];
    else
      r = v[8:0];
    return r;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - visible-area column/row counters driven by VGA blanking strobes
module raster_counter
  import paddle_mover_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HReset,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  output logic [9:0] o_X,
  output logic [8:0] o_Y
);

  localparam logic [9:0] X_LAST = 10'(H_VISIBLE_AREA - 1);
  localparam logic [8:0] Y_LAST = 9'(V_VISIBLE_AREA - 1);

  // Row only advances on visible lines, so it parks during vertical blanking.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_X <= '0;
      o_Y <= '0;
    end else begin
      if (!i_HBlank)
        o_X <= (o_X == X_LAST) ? 10'd0 : o_X + 10'd1;
      if (i_HReset && !i_VBlank)
        o_Y <= (o_Y == Y_LAST) ? 9'd0 : o_Y + 9'd1;
    end
  end

endmodule

// File: rtl/paddle_mover.sv
// rtl/paddle_mover.sv - manual or target-tracking paddle sprite, moved once per frame
module paddle_mover
  import paddle_mover_pkg::*;
#(
  parameter int P_X        = 40,
  parameter int P_START_Y  = 200,
  parameter int P_WIDTH    = 10,
  parameter int P_HEIGHT   = 50,
  parameter int P_SPEED    = 4,
  parameter int P_DEADBAND = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HReset,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Auto,
  input  logic [8:0] i_TargetY,
  output logic       o_Video,
  output logic [8:0] o_PaddleY
);

  if (P_X + P_WIDTH > H_VISIBLE_AREA) begin : g_chk_x
    $error("paddle_mover: P_X + P_WIDTH exceeds the visible width");
  end
  if (P_START_Y + P_HEIGHT > V_VISIBLE_AREA) begin : g_chk_y
    $error("paddle_mover: P_START_Y + P_HEIGHT exceeds the visible height");
  end
  if (P_SPEED < 1) begin : g_chk_speed
    $error("paddle_mover: P_SPEED must be at least 1");
  end

  localparam logic signed [10:0] SPEED    = 11'(P_SPEED);
  localparam logic signed [10:0] DEADBAND = 11'(P_DEADBAND);
  localparam logic signed [10:0] HALF_H   = 11'(P_HEIGHT / 2);
  localparam logic signed [10:0] TOP_MAX  = 11'(V_VISIBLE_AREA - P_HEIGHT);
  localparam logic [9:0]         X_LO     = 10'(P_X);
  localparam logic [9:0]         X_HI     = 10'(P_X + P_WIDTH);
  localparam logic [9:0]         HEIGHT   = 10'(P_HEIGHT);
  localparam logic [8:0]         START_Y  = 9'(P_START_Y);

  logic [9:0] x;
  logic [8:0] y;
  logic [8:0] top;
  logic [8:0] next_top;
  logic       vblank_q;
  logic       frame_tick;
  move_t      move;
  logic signed [10:0] top_s, err, abs_err, step, raw;

  raster_counter u_raster (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_HReset (i_HReset),
    .i_HBlank (i_HBlank),
    .i_VBlank (i_VBlank),
    .o_X      (x),
    .o_Y      (y)
  );

  assign frame_tick = i_VBlank & ~vblank_q;

  always_comb begin
    move    = MOVE_HOLD;
    step    = SPEED;
    top_s   = $signed({2'b00, top});
    err     = $signed({2'b00, i_TargetY}) - (top_s + HALF_H);
    abs_err = err[10] ? -err : err;
    if (i_Auto) begin
      if (err < -DEADBAND)
        move = MOVE_UP;
      else if (err > DEADBAND)
        move = MOVE_DOWN;
      // Shorten the last step so the centre lands on the target instead of hunting.
      if (abs_err < SPEED)
        step = abs_err;
    end else if (i_Up && !i_Down) begin
      move = MOVE_UP;
    end else if (i_Down && !i_Up) begin
      move = MOVE_DOWN;
    end
    case (move)
      MOVE_UP:   raw = top_s - step;
      MOVE_DOWN: raw = top_s + step;
      default:   raw = top_s;
    endcase
    next_top = clamp_row(raw, TOP_MAX);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      top      <= START_Y;
      vblank_q <= 1'b1;
    end else begin
      vblank_q <= i_VBlank;
      if (frame_tick)
        top <= next_top;
    end
  end

  assign o_PaddleY = top;
  assign o_Video   = i_Rst_n & ~i_HBlank & ~i_VBlank
                   & (x >= X_LO) & (x < X_HI)
                   & ({1'b0, y} >= {1'b0, top}) & ({1'b0, y} < ({1'b0, top} + HEIGHT));

endmodule

// File: tb/tb_paddle_mover.sv
// tb/tb_paddle_mover.sv - randomized and directed bench for paddle_mover against a frame-level model
module tb_paddle_mover;

  localparam int PX = 40, PW = 10, PH = 50, SPD = 4, DB = 2;
  localparam int TOP_MAX = 480 - PH;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n, i_HReset, i_HBlank, i_VBlank, i_Up, i_Down, i_Auto;
  logic [8:0] i_TargetY;
  logic       o_Video;
  logic [8:0] o_PaddleY;

  int drv_row, drv_col;
  int m_top;
  logic m_vb;
  int checks = 0, errors = 0, lit_cnt = 0;
  int base, r1, r2;
  int up_exp[3] = '{196, 192, 188};

  paddle_mover dut (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_HReset  (i_HReset),
    .i_HBlank  (i_HBlank),
    .i_VBlank  (i_VBlank),
    .i_Up      (i_Up),
    .i_Down    (i_Down),
    .i_Auto    (i_Auto),
    .i_TargetY (i_TargetY),
    .o_Video   (o_Video),
    .o_PaddleY (o_PaddleY)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic int model_next(int top, bit up, bit dn, bit au, int tgt);
    int err, t;
    t = top;
    if (au) begin
      err = tgt - (top + PH / 2);
      if (err > DB)       t = top + ((err < SPD) ? err : SPD);
      else if (err < -DB) t = top - ((-err < SPD) ? -err : SPD);
    end else if (up && !dn) t = top - SPD;
    else if (dn && !up)     t = top + SPD;
    if (t < 0) t = 0;
    if (t > TOP_MAX) t = TOP_MAX;
    return t;
  endfunction

  always @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      m_top <= 200;
      m_vb  <= 1'b1;
    end else begin
      m_vb <= i_VBlank;
      if (i_VBlank && !m_vb)
        m_top <= model_next(m_top, i_Up, i_Down, i_Auto, int'(i_TargetY));
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (row %0d col %0d)", name, act, exp, drv_row, drv_col);
    end
  endtask

  task automatic tick();
    bit ev;
    @(negedge i_Clk);
    ev = i_Rst_n && !i_HBlank && !i_VBlank && drv_col >= PX && drv_col < PX + PW
         && drv_row >= m_top && drv_row < m_top + PH;
    check("video", int'(o_Video), int'(ev));
    check("paddle_y", int'(o_PaddleY), m_top);
    if (o_Video) lit_cnt++;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic line(bit full);
    if (full) begin
      for (int c = 0; c < 640; c++) begin
        i_HBlank = 1'b0;
        drv_col  = c;
        tick();
      end
    end
    i_HBlank = 1'b1;
    drv_col  = -1;
    i_HReset = 1'b1;
    tick();
    i_HReset = 1'b0;
    tick();
  endtask

  task automatic frame(bit lines, int a1, int b1, int a2, int b2);
    i_VBlank = 1'b0;
    i_HBlank = 1'b1;
    if (lines) begin
      for (int r = 0; r < 480; r++) begin
        drv_row = r;
        line((r >= a1 && r <= b1) || (r >= a2 && r <= b2));
      end
    end else begin
      tick();
      tick();
    end
    i_VBlank = 1'b1;
    drv_row  = -1;
    repeat (3) tick();
  endtask

  task automatic manual_frames(bit up, bit dn, int n);
    i_Auto = 1'b0;
    i_Up   = up;
    i_Down = dn;
    repeat (n) frame(0, -1, -1, -1, -1);
  endtask

  initial begin
    i_Rst_n = 1'b0; i_HReset = 1'b0; i_HBlank = 1'b1; i_VBlank = 1'b1;
    i_Up = 1'b0; i_Down = 1'b0; i_Auto = 1'b0; i_TargetY = '0;
    drv_row = -1; drv_col = -1;
    repeat (3) @(posedge i_Clk);
    #1;
    check("reset_paddle_y", int'(o_PaddleY), 200);
    check("reset_video", int'(o_Video), 0);
    i_Rst_n = 1'b1;
    tick();

    base = lit_cnt;
    frame(1, 199, 250, -1, -1);
    check("lit_pixels_frame", lit_cnt - base, 500);
    check("idle_frame_y", int'(o_PaddleY), 200);

    for (int k = 0; k < 2; k++) begin
      manual_frames(1, 1, 1);
      check("both_hold", int'(o_PaddleY), 200);
    end
    for (int k = 0; k < 3; k++) begin
      manual_frames(1, 0, 1);
      check("up_step", int'(o_PaddleY), up_exp[k]);
    end

    manual_frames(0, 1, 60);
    check("down_to_428", int'(o_PaddleY), 428);
    manual_frames(0, 1, 1);
    check("down_clamp", int'(o_PaddleY), 430);
    manual_frames(0, 1, 1);
    check("down_stay", int'(o_PaddleY), 430);
    manual_frames(1, 0, 107);
    check("up_to_2", int'(o_PaddleY), 2);
    manual_frames(1, 0, 1);
    check("up_clamp", int'(o_PaddleY), 0);
    manual_frames(1, 0, 1);
    check("up_stay", int'(o_PaddleY), 0);
    manual_frames(0, 1, 50);
    check("back_to_200", int'(o_PaddleY), 200);

    i_Up = 1'b0; i_Down = 1'b0; i_Auto = 1'b1;
    i_TargetY = 9'd228; frame(0, -1, -1, -1, -1);
    check("auto_err3", int'(o_PaddleY), 203);
    frame(0, -1, -1, -1, -1);
    check("auto_err0", int'(o_PaddleY), 203);
    i_TargetY = 9'd229; frame(0, -1, -1, -1, -1);
    check("auto_err1", int'(o_PaddleY), 203);
    i_TargetY = 9'd226; frame(0, -1, -1, -1, -1);
    check("auto_err_m2", int'(o_PaddleY), 203);
    i_TargetY = 9'd225; frame(0, -1, -1, -1, -1);
    check("auto_err_m3", int'(o_PaddleY), 200);
    i_TargetY = 9'd226; frame(0, -1, -1, -1, -1);
    check("auto_hold", int'(o_PaddleY), 200);

    for (int i = 0; i < 40; i++) begin
      i_Up      = 1'($urandom_range(0, 1));
      i_Down    = 1'($urandom_range(0, 1));
      i_Auto    = 1'($urandom_range(0, 1));
      i_TargetY = 9'($urandom_range(0, 511));
      if (i % 4 == 0) begin
        r1 = m_top - 1 + int'($urandom_range(0, 1));
        r2 = m_top + PH - 2 + int'($urandom_range(0, 2));
        if (r1 < 0) r1 = 0;
        if (r2 > 479) r2 = 479;
        frame(1, r1, r1, r2, r2);
      end else begin
        frame(0, -1, -1, -1, -1);
      end
    end

    i_Auto = 1'b0; i_Up = 1'b0; i_Down = 1'b0;
    i_Rst_n = 1'b0;
    @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b1;
    tick();
    check("rearm_y", int'(o_PaddleY), 200);
    manual_frames(0, 1, 20);
    check("down_to_280", int'(o_PaddleY), 280);
    i_Down = 1'b0;

    i_VBlank = 1'b0;
    i_HBlank = 1'b1;
    for (int r = 0; r < 300; r++) begin
      drv_row = r;
      line(0);
    end
    drv_row = 300;
    base = lit_cnt;
    for (int c = 0; c < 45; c++) begin
      i_HBlank = 1'b0;
      drv_col  = c;
      tick();
    end
    check("row300_lit", lit_cnt - base, 5);
    drv_col = 45;
    i_Rst_n = 1'b0;
    #1;
    check("async_rst_video", int'(o_Video), 0);
    check("async_rst_y", int'(o_PaddleY), 200);
    repeat (4) tick();
    i_VBlank = 1'b1;
    i_HBlank = 1'b1;
    drv_row  = -1;
    drv_col  = -1;
    tick();
    i_Rst_n = 1'b1;
    tick();
    tick();

    base = lit_cnt;
    frame(1, 0, 0, 200, 200);
    check("post_reset_lit", lit_cnt - base, 10);
    check("post_reset_y", int'(o_PaddleY), 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paddle_mover.md
# paddle_mover

Parametrised, player- or auto-controlled paddle sprite for the VGA bouncing-ball/pong design. It sits beside the ball sprite and takes blanking and line-reset strobes from the VGA timing generator. It tracks the raster position, moves its vertical position once per frame from up/down buttons or by tracking a target Y, and drives a per-pixel video bit plus its current top coordinate for the collision logic.

## Interface
- P_X, 40: left column of paddle (0..H_VISIBLE_AREA-P_WIDTH)
- P_START_Y, 200: top row after reset
- P_WIDTH, 10: paddle width in pixels
- P_HEIGHT, 50: paddle height in pixels
- P_SPEED, 4: rows moved per frame (1..15)
- P_DEADBAND, 2: auto mode, |error| ≤ this → no move
- i_Clk  in  1  pixel clock
- i_Rst_n  in  1  asynchronous, active-low reset
- i_HReset  in  1  one-cycle pulse at start of each line
- i_HBlank  in  1  high outside visible columns
- i_VBlank  in  1  high outside visible rows
- i_Up  in  1  manual move up (held level)
- i_Down  in  1  manual move down (held level)
- i_Auto  in  1  1 = track i_TargetY, 0 = manual
- i_TargetY  in  9  row to track in auto mode (ball centre)
- o_Video  out  1  paddle pixel lit
- o_PaddleY  out  9  current top row of paddle

## Operation
- Raster column counter x (10 b): +1 each cycle with i_HBlank low; 639 → 0 wrap. Holds the column of the pixel being displayed.
- Raster row counter y (9 b): +1 on i_HReset while i_VBlank low; 479 → 0 wrap. Held during vertical blanking.
- Reset: x=0, y=0, paddle top=P_START_Y, vblank-edge register=1. Release reset only during vertical blanking so that row 0 aligns.
- Frame update fires on the i_VBlank rising edge, detected through a registered copy. Only that one cycle per frame updates the top row, so there is no tearing.
- Manual mode:
  - Up only → top −= P_SPEED.
  - Down only → top += P_SPEED.
  - Both or neither → hold.
- Auto mode:
  - err = i_TargetY − (top + P_HEIGHT/2), computed as 11-bit signed.
  - err < −P_DEADBAND → move up.
  - err > P_DEADBAND → move down.
  - Otherwise hold.
  - Step is min(P_SPEED, |err|), so the paddle never overshoots the target.
- Clamp: the new top is computed as 11-bit signed and saturated to [0, V_VISIBLE_AREA−P_HEIGHT] (0..430 at defaults). A request past a limit lands exactly on the limit.
- i_Auto and button changes take effect at the next vblank edge only.
- o_Video = ~i_HBlank & ~i_VBlank & x in [P_X, P_X+P_WIDTH) & y in [top, top+P_HEIGHT).

## Timing
- o_Video is combinational from registered counters plus the blanking inputs. Zero latency relative to the current pixel.
- o_PaddleY is registered. It changes one cycle after the cycle in which i_VBlank rises, and is stable for the whole visible frame.
- Asynchronous reset mid-frame: all state is reset immediately. o_Video is 0 while i_Rst_n is low. o_PaddleY = P_START_Y.
- i_HReset coinciding with the i_VBlank rising edge: the row counter does not increment (i_VBlank is already high). The position update still fires.
- Reset values of outputs: o_Video=0 and o_PaddleY=P_START_Y.

## Structure
- H_VISIBLE_AREA (640) and V_VISIBLE_AREA (480) come from the shared VGA timing constants include. The block defines no local copies.
- One sub-module, raster_counter: the x/y counters with wrap, reusable by the ball sprite.
- Position/clamp logic stays in paddle_mover.
- Elaboration-time checks:
  - P_X + P_WIDTH ≤ 640
  - P_START_Y + P_HEIGHT ≤ 480
  - P_SPEED ≥ 1

## Test plan
- Reset, then one full frame with no buttons → o_PaddleY=200; o_Video high exactly for x 40..49, y 200..249 (500 pixels per frame).
- i_Up held for 3 frames → o_PaddleY 196, 192, 188, each changing one cycle after the i_VBlank rise; no change mid-frame.
- i_Down held from top 428 → 430 next frame (clamped), then stays 430; i_Up from top 2 → 0.
- i_Up and i_Down both high for 2 frames → o_PaddleY unchanged at 200.
- Auto, top=200 (centre 225), i_TargetY=228 → err=3 > deadband, step=3 → 203; next frame err=0 → hold. i_TargetY=226 → err=1 → hold.
- i_Rst_n low for 5 cycles mid-line on visible row 300 with top=280 → o_Video drops at once; o_PaddleY=200 asynchronously; counters restart at 0 after release during vblank.
